// File: rtl/prbs15_checker.sv
// PRBS-15 (x^15+x^14+1) byte-stream checker: seeds from two bytes, verifies, then
// free-runs its predictor while locked. Define PRBS15_CHECKER_ERRCNT_EN to build bit_err_cnt.
`timescale 1ns/1ps
module prbs15_checker #(
  parameter int LOCK_THRESH = 2,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_byte,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [1:0]       dbg_state   // 0 SEED, 1 VERIFY, 2 LOCKED
);

  // Handshake: data_in is consumed on every rising edge where data_valid=1;
  // there is no backpressure and idle cycles leave all state untouched.

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam logic [3:0] LOCK_T = LOCK_THRESH[3:0];
  localparam logic [3:0] LOSS_T = LOSS_THRESH[3:0];

  state_e     state_q, state_d;
  logic [14:0] pred_q, pred_d;
  logic        have_first_q, have_first_d;
  logic [6:0]  byte1_q, byte1_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  bad_q, bad_d;
  logic        locked_q;
  logic        err_q, err_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic [14:0] pred_adv;
  logic [7:0]  pred_byte;
  logic [7:0]  diff;
  logic        byte_bad;
  logic [14:0] seed;
  logic        count_en;

  // Roll the predictor 8 bits forward; bit 0 of the state is the most recent bit.
  always_comb begin
    pred_adv  = pred_q;
    pred_byte = '0;
    for (int i = 0; i < 8; i++) begin
      pred_byte = {pred_byte[6:0], pred_adv[14] ^ pred_adv[13]};
      pred_adv  = {pred_adv[13:0], pred_adv[14] ^ pred_adv[13]};
    end
  end

  assign diff     = data_in ^ pred_byte;
  assign byte_bad = |diff;
  assign seed     = {byte1_q, data_in};
  assign count_en = data_valid && (state_q == ST_LOCKED);

  always_comb begin
    state_d      = state_q;
    pred_d       = pred_q;
    have_first_d = have_first_q;
    byte1_d      = byte1_q;
    match_d      = match_q;
    bad_d        = bad_q;
    err_d        = 1'b0;
    if (data_valid) begin
      case (state_q)
        ST_SEED: begin
          if (!have_first_q) begin
            byte1_d      = data_in[6:0];
            have_first_d = 1'b1;
          end else begin
            have_first_d = 1'b0;
            if (seed != 15'd0) begin
              pred_d  = seed;
              match_d = 4'd0;
              state_d = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (!byte_bad) begin
            pred_d  = pred_adv;
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 >= LOCK_T) begin
              state_d = ST_LOCKED;
              bad_d   = 4'd0;
            end
          end else begin
            match_d      = 4'd0;
            have_first_d = 1'b0;
            state_d      = ST_SEED;
          end
        end
        ST_LOCKED: begin
          // Free-run on our own prediction so a corrupted byte cannot poison the next one.
          pred_d = pred_adv;
          if (byte_bad) begin
            err_d = 1'b1;
            bad_d = bad_q + 4'd1;
            if (bad_q + 4'd1 >= LOSS_T) begin
              bad_d        = 4'd0;
              have_first_d = 1'b0;
              state_d      = ST_SEED;
            end
          end else begin
            bad_d = 4'd0;
          end
        end
        default: state_d = ST_SEED;
      endcase
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (clear_cnt) begin
      byte_cnt_d = '0;
    end else if (count_en && (byte_cnt_q != {CNT_W{1'b1}})) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SEED;
      pred_q       <= '0;
      have_first_q <= 1'b0;
      byte1_q      <= '0;
      match_q      <= '0;
      bad_q        <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      have_first_q <= have_first_d;
      byte1_q      <= byte1_d;
      match_q      <= match_d;
      bad_q        <= bad_d;
      locked_q     <= (state_d == ST_LOCKED);
      err_q        <= err_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

`ifdef PRBS15_CHECKER_ERRCNT_EN
  logic [3:0]       pop;
  logic [CNT_W+3:0] bec_sum;
  logic [CNT_W-1:0] bec_q, bec_d;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 8; i++) begin
      pop = pop + {3'b000, diff[i]};
    end
  end

  // Extra headroom bits make the saturation test a simple overflow check.
  assign bec_sum = {4'b0000, bec_q} + {{CNT_W{1'b0}}, pop};

  always_comb begin
    bec_d = bec_q;
    if (clear_cnt) begin
      bec_d = '0;
    end else if (count_en) begin
      bec_d = (bec_sum[CNT_W+3:CNT_W] != 4'd0) ? {CNT_W{1'b1}} : bec_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bec_q <= '0;
    else     bec_q <= bec_d;
  end

  assign bit_err_cnt = bec_q;
`else
  assign bit_err_cnt = '0;
`endif

  assign locked    = locked_q;
  assign err_byte  = err_q;
  assign byte_cnt  = byte_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prbs15_checker.sv
// Bench for prbs15_checker: directed vector table, corner-case sequences and
// randomized traffic against a bit-level reference model (32-bit and 4-bit counter builds).
`timescale 1ns/1ps
module tb_prbs15_checker;
  localparam int LT = 2;
  localparam int LS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        clear_cnt;
  logic        locked_a, err_a, locked_b, err_b;
  logic [31:0] bec_a, bc_a;
  logic [3:0]  bec_b, bc_b;
  logic [1:0]  st_a, st_b;

  int checks = 0;
  int errors = 0;

  prbs15_checker #(.LOCK_THRESH(LT), .LOSS_THRESH(LS), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clear_cnt(clear_cnt),
    .locked(locked_a), .err_byte(err_a), .bit_err_cnt(bec_a), .byte_cnt(bc_a), .dbg_state(st_a));

  prbs15_checker #(.LOCK_THRESH(LT), .LOSS_THRESH(LS), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .clear_cnt(clear_cnt),
    .locked(locked_b), .err_byte(err_b), .bit_err_cnt(bec_b), .byte_cnt(bc_b), .dbg_state(st_b));

  always #5 clk = ~clk;

  // ---------------- generator: true PRBS-15 bit stream ----------------
  bit gq[$];

  task automatic gen_reset();
    gq.delete();
    repeat (15) gq.push_back(1'b1);
  endtask

  task automatic gen_byte(output logic [7:0] b);
    bit nb;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      nb = gq[0] ^ gq[1];            // b(n-15) ^ b(n-14)
      gq.push_back(nb);
      void'(gq.pop_front());
      b = {b[6:0], nb};
    end
  endtask

  // ---------------- reference model ----------------
  int              m_mode;            // 0 SEED, 1 VERIFY, 2 LOCKED
  bit              m_first;
  logic [6:0]      m_b1;
  bit              mh[$];             // last 15 bits, oldest first
  int              m_match, m_bad;
  longint unsigned m_bc, m_bec;
  bit              m_err;

  task automatic model_reset();
    m_mode = 0; m_first = 0; m_b1 = '0; mh.delete();
    m_match = 0; m_bad = 0; m_bc = 0; m_bec = 0; m_err = 0;
  endtask

  task automatic model_predict(output logic [7:0] p);
    bit nb;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      nb = mh[0] ^ mh[1];
      mh.push_back(nb);
      void'(mh.pop_front());
      p = {p[6:0], nb};
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic [15:0] s;
    logic [7:0]  p;
    int          pc;
    m_err = 0;
    if (v) begin
      case (m_mode)
        0: begin
          if (!m_first) begin
            m_b1 = d[6:0]; m_first = 1;
          end else begin
            m_first = 0;
            s = {1'b0, m_b1, d};
            if (s != 16'd0) begin
              mh.delete();
              for (int i = 14; i >= 0; i--) mh.push_back(s[i]);
              m_mode = 1; m_match = 0;
            end
          end
        end
        1: begin
          model_predict(p);
          if (d == p) begin
            m_match++;
            if (m_match >= LT) begin m_mode = 2; m_bad = 0; end
          end else begin
            m_mode = 0; m_match = 0; m_first = 0;
          end
        end
        default: begin
          model_predict(p);
          pc = $countones(d ^ p);
          m_bc++;
          m_bec += longint'(pc);
          if (pc != 0) begin
            m_err = 1;
            m_bad++;
            if (m_bad >= LS) begin m_mode = 0; m_bad = 0; m_first = 0; end
          end else begin
            m_bad = 0;
          end
        end
      endcase
    end
    if (c) begin m_bc = 0; m_bec = 0; end
  endtask

  function automatic longint unsigned sat(input longint unsigned raw, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (raw > mx) ? mx : raw;
  endfunction

  function automatic longint unsigned exp_bec(input int w);
`ifdef PRBS15_CHECKER_ERRCNT_EN
    return sat(m_bec, w);
`else
    return 64'd0 + 0 * w;
`endif
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("locked_a",  64'(locked_a), 64'(m_mode == 2));
    chk("err_a",     64'(err_a),    64'(m_err));
    chk("byte_cnt_a",64'(bc_a),     sat(m_bc, 32));
    chk("bit_err_a", 64'(bec_a),    exp_bec(32));
    chk("state_a",   64'(st_a),     64'(m_mode));
    chk("locked_b",  64'(locked_b), 64'(m_mode == 2));
    chk("err_b",     64'(err_b),    64'(m_err));
    chk("byte_cnt_b",64'(bc_b),     sat(m_bc, 4));
    chk("bit_err_b", 64'(bec_b),    exp_bec(4));
  endtask

  // Driver: inputs change at the falling edge, outputs sampled at the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic c);
    data_valid = v; data_in = d; clear_cnt = c;
    @(posedge clk);
    model_step(v, d, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic stream(input logic v, input logic [7:0] mask, input logic c);
    logic [7:0] b;
    if (v) gen_byte(b);
    else   b = 8'($urandom_range(0, 255));
    cycle(v, b ^ mask, c);
  endtask

  task automatic do_reset();
    data_valid = 0; clear_cnt = 0; data_in = '0;
    rst = 1'b1;
    model_reset();
    gen_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] mask;
    logic       clr;
    logic       e_locked;
    logic       e_err;
    int         e_bc;
    int         e_bec;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic [7:0] m, input logic c, input logic l,
                              input logic e, input int bc, input int bec);
    vec_t r;
    r.mask = m; r.clr = c; r.e_locked = l; r.e_err = e; r.e_bc = bc; r.e_bec = bec;
    return r;
  endfunction

  initial begin
    logic [7:0] b;
    int         exp_tbl_bec;

    for (int i = 0; i < 4; i++)   tbl[i] = mk(8'h00, 1'b0, (i == 3), 1'b0, 0, 0);
    for (int i = 4; i < 14; i++)  tbl[i] = mk(8'h00, 1'b0, 1'b1, 1'b0, i - 3, 0);
    tbl[14] = mk(8'h01, 1'b0, 1'b1, 1'b1, 11, 1);
    tbl[15] = mk(8'h00, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 16; i < 20; i++) tbl[i] = mk(8'hFF, 1'b0, (i < 19), 1'b1, i - 15, 8 * (i - 15));
    for (int i = 20; i < 24; i++) tbl[i] = mk(8'h00, 1'b0, (i == 23), 1'b0, 4, 32);

    // Reset state and first stream bytes from a 0x7FFF-seeded generator.
    do_reset();
    gen_byte(b); chk("first_byte_gen_00", 64'(b), 64'h00);
    gen_reset();

    for (int i = 0; i < 24; i++) begin
      stream(1'b1, tbl[i].mask, tbl[i].clr);
`ifdef PRBS15_CHECKER_ERRCNT_EN
      exp_tbl_bec = tbl[i].e_bec;
`else
      exp_tbl_bec = 0;
`endif
      chk($sformatf("tbl%0d_locked", i),  64'(locked_a), 64'(tbl[i].e_locked));
      chk($sformatf("tbl%0d_err", i),     64'(err_a),    64'(tbl[i].e_err));
      chk($sformatf("tbl%0d_byte_cnt", i),64'(bc_a),     64'(tbl[i].e_bc));
      chk($sformatf("tbl%0d_bit_err", i), 64'(bec_a),    64'(exp_tbl_bec));
    end

    // All-zero input never seeds.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'h00, 1'b0);
    chk("zeros_state_seed", 64'(st_a), 64'd0);
    chk("zeros_locked",     64'(locked_a), 64'd0);
    chk("zeros_byte_cnt",   64'(bc_a), 64'd0);

    // Alternating data_valid: lock after 4 valid bytes.
    do_reset();
    for (int i = 0; i < 8; i++) stream((i % 2) == 0, 8'h00, 1'b0);
    chk("toggle_locked_after4", 64'(locked_a), 64'd1);
    for (int i = 0; i < 6; i++) stream((i % 2) == 0, 8'h00, 1'b0);
    chk("toggle_byte_cnt", 64'(bc_a), 64'd3);

    // Saturation of the 4-bit counters, then clear coincident with an error byte.
    for (int i = 0; i < 20; i++) stream(1'b1, 8'h00, 1'b0);
    chk("sat_byte_cnt_b", 64'(bc_b), 64'd15);
    stream(1'b1, 8'hFF, 1'b0);
    stream(1'b1, 8'hFF, 1'b0);
`ifdef PRBS15_CHECKER_ERRCNT_EN
    chk("sat_bit_err_b", 64'(bec_b), 64'd15);
`endif
    stream(1'b1, 8'hFF, 1'b1);
    chk("clr_vs_inc_byte_cnt_b", 64'(bc_b), 64'd0);
    chk("clr_vs_inc_bit_err_b",  64'(bec_b), 64'd0);
    chk("clr_err_pulse",         64'(err_b), 64'd1);
    chk("clr_keeps_lock",        64'(locked_b), 64'd1);

    // Asynchronous reset mid-seed: partial seed discarded, stream continues.
    do_reset();
    stream(1'b1, 8'h00, 1'b0);
    data_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked", 64'(locked_a), 64'd0);
    chk("async_rst_state",  64'(st_a), 64'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) stream(1'b1, 8'h00, 1'b0);
    chk("resync_locked", 64'(locked_a), 64'd1);

    // Randomized traffic with sparse corruption, error bursts and clears.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 60) == 0) begin
        for (int k = 0; k < int'($urandom_range(2, 6)); k++)
          stream(1'b1, 8'($urandom_range(1, 255)), 1'b0);
      end else begin
        stream($urandom_range(0, 3) != 0,
               ($urandom_range(0, 12) == 0) ? 8'($urandom_range(0, 255)) : 8'h00,
               $urandom_range(0, 40) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
